// File: rtl/jt12_wr_queue_if.sv
// Bus bundle between the host/register-map side and the write queue.
// The master side drives the CPU strobes and the register map's busy line.
// The slave side, which is the queue, drives status and the replayed writes.
interface jt12_wr_queue_if #(
  parameter int AW = 4
);
  // CPU side
  logic          cpu_wr;
  logic [1:0]    cpu_addr;
  logic [7:0]    cpu_din;
  logic          flush;
  logic          flag_clr;

  // Status
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          ovf;
  logic          tout;

  // Register-map side
  logic          mmr_write;
  logic [1:0]    mmr_addr;
  logic [7:0]    mmr_din;
  logic          mmr_busy;

  modport master (
    output cpu_wr, cpu_addr, cpu_din, flush, flag_clr, mmr_busy,
    input  full, empty, level, ovf, tout, mmr_write, mmr_addr, mmr_din
  );

  modport slave (
    input  cpu_wr, cpu_addr, cpu_din, flush, flag_clr, mmr_busy,
    output full, empty, level, ovf, tout, mmr_write, mmr_addr, mmr_din
  );
endinterface

// File: rtl/jt12_wr_queue.sv
// CPU write buffer in front of the FM register map.
// Stores {addr,data} writes in order and replays them as single-cycle
// write pulses, waiting for the map's busy to clear between writes.
module jt12_wr_queue #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  jt12_wr_queue_if.slave  bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(2**AW);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RELEASE,
    WAIT_BUSY
  } state_t;

  state_t          state, state_next;
  logic [9:0]      mem [2**AW];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_next;
  logic            full_q, empty_q;
  logic            ovf_q, tout_q;
  logic [7:0]      tcnt, tcnt_next;
  logic            mmr_write_q;
  logic [1:0]      mmr_addr_q;
  logic [7:0]      mmr_din_q;
  logic            push, drop, pop, tout_set;

  // full is the registered view of count, so a write into a full queue is
  // judged before any pop in the same cycle. flush discards the write and
  // does not count as an overflow.
  assign push = bus.cpu_wr &&  !full_q && !bus.flush;
  assign drop = bus.cpu_wr &&   full_q && !bus.flush;

  // Next-state and pop decision for the replay FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    tcnt_next  = tcnt;
    pop        = 1'b0;
    tout_set   = 1'b0;
    unique case (state)
      IDLE: begin
        // A flush in this cycle empties the queue, so do not pop from it.
        if (!empty_q && !bus.mmr_busy && !bus.flush) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE:   state_next = RELEASE;
      RELEASE: begin
        tcnt_next  = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Wait at most TIMEOUT cycles in this state, then give up.
        if (!bus.mmr_busy) begin
          state_next = IDLE;
        end else if (tcnt == 8'(TIMEOUT - 1)) begin
          tout_set   = 1'b1;
          state_next = IDLE;
        end else begin
          tcnt_next  = tcnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Queue occupancy: flush wins, push and pop together leave count as is.
  always_comb begin
    count_next = count;
    if (bus.flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count + (AW+1)'(1);
    else if (!push && pop)
      count_next = count - (AW+1)'(1);
  end

  // Pointers, count and the registered full/empty view of the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count   <= count_next;
      full_q  <= (count_next == DEPTH_C);
      empty_q <= (count_next == '0);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; count/pointers define which entries are
    // valid, and leaving it unreset lets it map onto plain RAM.
    if (push) mem[wr_ptr] <= {bus.cpu_addr, bus.cpu_din};
  end

  // FSM state, busy-wait counter and the latched register-map outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      mmr_write_q <= 1'b0;
      mmr_addr_q  <= '0;
      mmr_din_q   <= '0;
    end else begin
      state       <= state_next;
      tcnt        <= tcnt_next;
      mmr_write_q <= (state_next == DRIVE);
      if (pop) {mmr_addr_q, mmr_din_q} <= mem[rd_ptr];
    end
  end

  // Sticky flags: a set event in the same cycle as flag_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      tout_q <= 1'b0;
    end else begin
      ovf_q  <= drop     | (ovf_q  & ~bus.flag_clr);
      tout_q <= tout_set | (tout_q & ~bus.flag_clr);
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.level     = count;
  assign bus.ovf       = ovf_q;
  assign bus.tout      = tout_q;
  assign bus.mmr_write = mmr_write_q;
  assign bus.mmr_addr  = mmr_addr_q;
  assign bus.mmr_din   = mmr_din_q;

endmodule

// File: tb/tb_jt12_wr_queue.sv
// Directed bench for jt12_wr_queue: a scoreboard of expected {addr,data}
// writes filled at push time and compared against observed write pulses.
module tb_jt12_wr_queue;

  localparam int AW      = 4;
  localparam int TIMEOUT = 255;

  typedef struct {
    int         cyc;
    logic [9:0] ad;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jt12_wr_queue_if #(.AW(AW)) bus ();

  jt12_wr_queue #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [9:0] exp_q[$];
  obs_t       obs_q[$];
  int         cyc_hist[$];

  logic       busy_manual = 1'b0;
  logic       busy_auto   = 1'b0;
  logic       auto_en     = 1'b0;
  int         bcnt        = 0;
  logic       wr_prev     = 1'b0;
  logic       track       = 1'b0;
  logic [AW:0] lvl_max    = '0;

  assign bus.mmr_busy = auto_en ? busy_auto : busy_manual;

  // Cycle stamp for spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every rising edge of mmr_write with its address/data.
  always @(negedge clk) begin
    if (bus.mmr_write && !wr_prev) obs_q.push_back('{cyc, {bus.mmr_addr, bus.mmr_din}});
    wr_prev <= bus.mmr_write;
  end

  // Register-map model: busy goes high after a pulse and stays 40 cycles.
  always @(negedge clk) begin
    if (!auto_en) begin
      busy_auto <= 1'b0;
      bcnt      <= 0;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) busy_auto <= 1'b0;
    end else if (bus.mmr_write) begin
      busy_auto <= 1'b1;
      bcnt      <= 40;
    end
  end

  // Peak fill level while tracking is on.
  always @(negedge clk) begin
    if (!track) lvl_max <= '0;
    else if (bus.level > lvl_max) lvl_max <= bus.level;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_empty"}, 32'(bus.empty), 1);
    check({tag, "_full"},  32'(bus.full), 0);
    check({tag, "_level"}, 32'(bus.level), 0);
    check({tag, "_ovf"},   32'(bus.ovf), 0);
    check({tag, "_tout"},  32'(bus.tout), 0);
    check({tag, "_write"}, 32'(bus.mmr_write), 0);
    check({tag, "_addr"},  32'(bus.mmr_addr), 0);
    check({tag, "_din"},   32'(bus.mmr_din), 0);
  endtask

  task automatic push(input logic [1:0] a, input logic [7:0] d, input bit stored);
    bus.cpu_wr   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    if (stored) exp_q.push_back({a, d});
    @(negedge clk);
    bus.cpu_wr = 1'b0;
  endtask

  task automatic wait_write(input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.mmr_write && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.mmr_write), 1);
  endtask

  task automatic drain(input int n, input int budget, input string tag);
    int   waited = 0;
    obs_t o;
    cyc_hist.delete();
    while (obs_q.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_arrived"}, 32'(obs_q.size() >= n), 1);
    for (int i = 0; i < n; i++) begin
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front();
      cyc_hist.push_back(o.cyc);
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, 32'(o.ad), 32'hFFFF_FFFF);
      end else begin
        check({tag, "_data"}, 32'(o.ad), 32'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 2'd0;
    bus.cpu_din  = 8'd0;
    bus.flush    = 1'b0;
    bus.flag_clr = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single pair with busy low: pulses at t2 and t6.
    bus.cpu_wr = 1'b1; bus.cpu_addr = 2'd0; bus.cpu_din = 8'h28;
    exp_q.push_back(10'h028);
    @(negedge clk);
    check("pair_level_t1", 32'(bus.level), 1);
    check("pair_empty_t1", 32'(bus.empty), 0);
    bus.cpu_addr = 2'd1; bus.cpu_din = 8'hF0;
    exp_q.push_back(10'h1F0);
    @(negedge clk);
    bus.cpu_wr = 1'b0;
    check("pair_write_t2", 32'(bus.mmr_write), 1);
    check("pair_ad_t2", 32'({bus.mmr_addr, bus.mmr_din}), 32'h028);
    check("pair_level_t2", 32'(bus.level), 1);
    repeat (4) @(negedge clk);
    check("pair_write_t6", 32'(bus.mmr_write), 1);
    check("pair_ad_t6", 32'({bus.mmr_addr, bus.mmr_din}), 32'h1F0);
    check("pair_level_t6", 32'(bus.level), 0);
    check("pair_empty_t6", 32'(bus.empty), 1);
    drain(2, 20, "pair_sb");
    if (cyc_hist.size() == 2) check("pair_spacing", 32'(cyc_hist[1] - cyc_hist[0]), 4);
    repeat (6) @(negedge clk);

    // Busy stall: map holds busy 40 cycles after every pulse.
    auto_en = 1'b1;
    push(2'd0, 8'h30, 1'b1);
    push(2'd1, 8'h31, 1'b1);
    push(2'd2, 8'h32, 1'b1);
    drain(3, 200, "stall_sb");
    if (cyc_hist.size() == 3) begin
      check("stall_gap01", 32'(cyc_hist[1] - cyc_hist[0] >= 42), 1);
      check("stall_gap12", 32'(cyc_hist[2] - cyc_hist[1] >= 42), 1);
    end
    check("stall_tout", 32'(bus.tout), 0);
    repeat (50) @(negedge clk);
    auto_en = 1'b0;
    repeat (4) @(negedge clk);

    // Overflow: busy held, 17 pushes into a 16-deep queue.
    busy_manual = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      push(2'(i), 8'(i), i < 16);
      if (i == 15) begin
        check("ovf_full_16", 32'(bus.full), 1);
        check("ovf_level_16", 32'(bus.level), 16);
        check("ovf_flag_16", 32'(bus.ovf), 0);
      end
    end
    check("ovf_flag_17", 32'(bus.ovf), 1);
    check("ovf_level_17", 32'(bus.level), 16);
    // Dropped push together with flag_clr: the set wins.
    bus.cpu_wr = 1'b1; bus.cpu_din = 8'h11; bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.flag_clr = 1'b0;
    check("ovf_set_wins", 32'(bus.ovf), 1);
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    check("ovf_cleared", 32'(bus.ovf), 0);
    busy_manual = 1'b0;
    drain(16, 150, "ovf_sb");
    repeat (10) @(negedge clk);
    check("ovf_no_extra", 32'(obs_q.size()), 0);
    check("ovf_empty_end", 32'(bus.empty), 1);

    // Timeout: busy sticks high after the pulse.
    push(2'd2, 8'h55, 1'b1);
    wait_write(20, "tmo_pulse");
    busy_manual = 1'b1;
    repeat (255) @(negedge clk);
    check("tmo_not_early", 32'(bus.tout), 0);
    repeat (3) @(negedge clk);
    check("tmo_set", 32'(bus.tout), 1);
    drain(1, 5, "tmo_sb");
    push(2'd3, 8'h66, 1'b1);
    repeat (20) @(negedge clk);
    check("tmo_no_pulse", 32'(obs_q.size()), 0);
    check("tmo_held_level", 32'(bus.level), 1);
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    check("tmo_cleared", 32'(bus.tout), 0);
    busy_manual = 1'b0;
    drain(1, 20, "tmo_sb2");
    repeat (6) @(negedge clk);

    // Stream 40 entries, one every 4 cycles: pointers wrap, level stays <= 1.
    track = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(2'(i), 8'(8'h80 + i), 1'b1);
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("stream_lvl_max", 32'(lvl_max <= 1), 1);
    track = 1'b0;
    drain(40, 20, "stream_sb");
    repeat (4) @(negedge clk);

    // Flush with a pulse parked in WAIT_BUSY and 5 entries queued.
    push(2'd0, 8'h01, 1'b1);
    wait_write(20, "flush_pulse");
    busy_manual = 1'b1;
    for (int i = 1; i <= 5; i++) push(2'(i), 8'(8'hA0 + i), 1'b0);
    check("flush_level_5", 32'(bus.level), 5);
    bus.flush = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_din = 8'hEE;
    @(negedge clk);
    bus.flush = 1'b0; bus.cpu_wr = 1'b0;
    check("flush_level_0", 32'(bus.level), 0);
    check("flush_empty", 32'(bus.empty), 1);
    check("flush_no_ovf", 32'(bus.ovf), 0);
    busy_manual = 1'b0;
    drain(1, 10, "flush_sb");
    repeat (20) @(negedge clk);
    check("flush_no_more", 32'(obs_q.size()), 0);

    // Asynchronous reset while a pulse is being driven.
    push(2'd2, 8'h77, 1'b1);
    wait_write(20, "rst_pulse");
    rst_n = 1'b0;
    #1;
    check_reset("rst_drive");
    drain(1, 2, "rst_sb");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_more", 32'(obs_q.size()), 0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
